// File: rtl/mem_bus_master.sv
// Avalon-MM master sequencer. Takes one word-aligned fetch/load/store request at a time
// from the load/store unit, runs it on the bus and returns a one-cycle response pulse.
module mem_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   // Request from load/store unit
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_address,
   input  logic [3:0]  req_byteenable,
   input  logic [31:0] req_writedata,
   // Response to load/store unit
   output logic        rsp_valid,
   output logic [31:0] rsp_readdata,
   output logic        rsp_error,
   // Avalon-MM master
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
   // Counter value on the last permitted stalled cycle; the abort happens on that edge.
   localparam logic [CNT_W-1:0] CntLast =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_readdata_q;
   logic              rsp_error_q;
   logic [31:0]       avm_address_q;
   logic              avm_read_q;
   logic              avm_write_q;
   logic [3:0]        avm_byteenable_q;
   logic [31:0]       avm_writedata_q;

   logic              req_bad;
   logic [31:0]       lane_mask;

   // Request is rejected without touching the bus when misaligned or with no lanes enabled.
   always_comb begin
      req_bad = (req_address[1:0] != 2'b00) || (req_byteenable == 4'b0000);
   end

   // Expand the captured byteenable into a 32-bit lane mask for read data.
   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < 4; i++) begin
         lane_mask[8*i +: 8] = {8{avm_byteenable_q[i]}};
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= StIdle;
         cnt_q            <= '0;
         req_ready_q      <= 1'b0;
         rsp_valid_q      <= 1'b0;
         rsp_readdata_q   <= '0;
         rsp_error_q      <= 1'b0;
         avm_address_q    <= '0;
         avm_read_q       <= 1'b0;
         avm_write_q      <= 1'b0;
         avm_byteenable_q <= '0;
         avm_writedata_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               rsp_valid_q    <= 1'b0;
               rsp_readdata_q <= '0;
               rsp_error_q    <= 1'b0;
               // req_ready rises on the first edge after reset; accept only once it is up.
               if (req_ready_q && req_valid) begin
                  req_ready_q <= 1'b0;
                  if (req_bad) begin
                     rsp_valid_q <= 1'b1;
                     rsp_error_q <= 1'b1;
                     state_q     <= StResp;
                  end else begin
                     avm_address_q    <= req_address;
                     avm_byteenable_q <= req_byteenable;
                     avm_writedata_q  <= req_write ? req_writedata : 32'h0;
                     avm_write_q      <= req_write;
                     avm_read_q       <= !req_write;
                     cnt_q            <= '0;
                     state_q          <= StBus;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            StBus: begin
               if (!avm_waitrequest) begin
                  rsp_readdata_q <= avm_read_q ? (avm_readdata & lane_mask) : 32'h0;
                  rsp_error_q    <= 1'b0;
                  rsp_valid_q    <= 1'b1;
                  avm_read_q     <= 1'b0;
                  avm_write_q    <= 1'b0;
                  state_q        <= StResp;
               end else if (TimeoutEn && (cnt_q == CntLast)) begin
                  rsp_readdata_q <= '0;
                  rsp_error_q    <= 1'b1;
                  rsp_valid_q    <= 1'b1;
                  avm_read_q     <= 1'b0;
                  avm_write_q    <= 1'b0;
                  state_q        <= StResp;
               end else if (cnt_q != CntMax) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StResp: begin
               rsp_valid_q    <= 1'b0;
               rsp_readdata_q <= '0;
               rsp_error_q    <= 1'b0;
               req_ready_q    <= 1'b1;
               state_q        <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_readdata   = rsp_readdata_q;
   assign rsp_error      = rsp_error_q;
   assign avm_address    = avm_address_q;
   assign avm_read       = avm_read_q;
   assign avm_write      = avm_write_q;
   assign avm_byteenable = avm_byteenable_q;
   assign avm_writedata  = avm_writedata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed cases plus randomized transactions
// checked against a transaction-level reference of latency, bus occupancy and response.
module tb_mem_bus_master;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_address = '0;
   logic [3:0]  req_byteenable = '0;
   logic [31:0] req_writedata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_readdata;
   logic        rsp_error;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   mem_bus_master #(
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_address    (req_address),
      .req_byteenable (req_byteenable),
      .req_writedata  (req_writedata),
      .rsp_valid      (rsp_valid),
      .rsp_readdata   (rsp_readdata),
      .rsp_error      (rsp_error),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_write      (avm_write),
      .avm_byteenable (avm_byteenable),
      .avm_writedata  (avm_writedata),
      .avm_readdata   (avm_readdata),
      .avm_waitrequest(avm_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, act as the Avalon slave (nwait stalls, then readdata) and compare the
   // observed transaction against the expected one.
   task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int nwait);
      int          exp_bus;
      int          exp_lat;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          guard;
      int          cycle;
      int          bus_cnt;
      int          bad;
      int          both;
      int          stalls;
      int          got_lat;
      logic [31:0] got_rd;
      logic        got_err;

      exp_rd = '0;
      if ((addr[1:0] != 2'b00) || (be == 4'b0000)) begin
         exp_bus = 0;
         exp_lat = 1;
         exp_err = 1'b1;
      end else if (nwait >= int'(TO)) begin
         exp_bus = int'(TO);
         exp_lat = int'(TO) + 1;
         exp_err = 1'b1;
      end else begin
         exp_bus = nwait + 1;
         exp_lat = nwait + 2;
         exp_err = 1'b0;
         if (!wr) begin
            for (int i = 0; i < 4; i++) exp_rd[8*i +: 8] = be[i] ? rdata[8*i +: 8] : 8'h00;
         end
      end

      guard = 0;
      while (!req_ready && guard < 10) begin
         step();
         guard++;
      end
      chk({tag, "/ready"}, 32'(req_ready), 32'd1);

      req_write      = wr;
      req_address    = addr;
      req_byteenable = be;
      req_writedata  = wdata;
      req_valid      = 1'b1;
      step();
      req_valid = 1'b0;

      cycle   = 1;
      bus_cnt = 0;
      bad     = 0;
      both    = 0;
      stalls  = 0;
      got_lat = 0;
      got_rd  = 'x;
      got_err = 1'bx;
      while (cycle <= 300) begin
         if (avm_read || avm_write) begin
            bus_cnt++;
            if (avm_read && avm_write) both++;
            if (avm_address !== addr || avm_byteenable !== be || avm_write !== wr ||
                avm_writedata !== (wr ? wdata : 32'h0)) bad++;
            if (stalls < nwait) begin
               avm_waitrequest = 1'b1;
               avm_readdata    = $urandom;
               stalls++;
            end else begin
               avm_waitrequest = 1'b0;
               avm_readdata    = rdata;
            end
         end else begin
            avm_waitrequest = 1'($urandom_range(0, 1));
            avm_readdata    = $urandom;
         end
         if (rsp_valid) begin
            got_lat = cycle;
            got_rd  = rsp_readdata;
            got_err = rsp_error;
            break;
         end
         step();
         cycle++;
      end
      avm_waitrequest = 1'b0;

      chk({tag, "/latency"}, 32'(got_lat), 32'(exp_lat));
      chk({tag, "/bus_cycles"}, 32'(bus_cnt), 32'(exp_bus));
      chk({tag, "/bus_stable"}, 32'(bad), 32'd0);
      chk({tag, "/rd_wr_exclusive"}, 32'(both), 32'd0);
      chk({tag, "/rsp_readdata"}, got_rd, exp_rd);
      chk({tag, "/rsp_error"}, 32'(got_err), 32'(exp_err));

      step();
      chk({tag, "/rsp_pulse"}, 32'(rsp_valid), 32'd0);
      chk({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "/idle_rd0"}, rsp_readdata, 32'h0);
      chk({tag, "/idle_bus"}, 32'({avm_read, avm_write}), 32'd0);
   endtask

   initial begin
      logic        wr;
      logic [31:0] a;
      logic [3:0]  be;

      #2 rst_n = 1'b0;
      #1;
      chk("reset/req_ready", 32'(req_ready), 32'd0);
      chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset/rsp_error", 32'(rsp_error), 32'd0);
      chk("reset/rsp_readdata", rsp_readdata, 32'h0);
      chk("reset/avm_rw", 32'({avm_read, avm_write}), 32'd0);
      chk("reset/avm_address", avm_address, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      chk("post_reset/ready_low", 32'(req_ready), 32'd0);
      step();
      chk("post_reset/ready_high", 32'(req_ready), 32'd1);

      run_txn("rd_nowait", 1'b0, 32'h0000_1000, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0);
      run_txn("rd_wait3", 1'b0, 32'h0000_3000, 4'b0100, 32'h0, 32'h1122_3344, 3);
      run_txn("wr_wait2", 1'b1, 32'h0000_2004, 4'b0011, 32'h0000_ABCD, 32'hFFFF_FFFF, 2);
      run_txn("misaligned", 1'b0, 32'h0000_1002, 4'b1111, 32'h0, 32'h1234_5678, 0);
      run_txn("be_empty", 1'b1, 32'h0000_1000, 4'b0000, 32'h5555_AAAA, 32'h0, 0);
      run_txn("timeout", 1'b0, 32'h0000_5000, 4'b1111, 32'h0, 32'hCAFE_F00D, 1000);
      run_txn("after_timeout", 1'b0, 32'h0000_5004, 4'b1001, 32'h0, 32'hA1B2_C3D4, 1);
      run_txn("wr_timeout", 1'b1, 32'h0000_6000, 4'b1111, 32'h1357_9BDF, 32'h0, 4);

      for (int n = 0; n < 30; n++) begin
         wr = 1'($urandom_range(0, 1));
         a  = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         be = 4'($urandom_range(0, 15));
         run_txn($sformatf("rand%0d", n), wr, a, be, $urandom, $urandom,
                 int'($urandom_range(0, 5)));
      end

      // Reset while a read is stalled on the bus.
      req_write      = 1'b0;
      req_address    = 32'h0000_4000;
      req_byteenable = 4'b1111;
      req_valid      = 1'b1;
      step();
      req_valid       = 1'b0;
      avm_waitrequest = 1'b1;
      step();
      step();
      chk("rst_mid/read_active", 32'(avm_read), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid/read_dropped", 32'(avm_read), 32'd0);
      chk("rst_mid/ready_low", 32'(req_ready), 32'd0);
      chk("rst_mid/no_rsp", 32'(rsp_valid), 32'd0);
      step();
      step();
      chk("rst_mid/still_no_rsp", 32'(rsp_valid), 32'd0);
      avm_waitrequest = 1'b0;
      rst_n = 1'b1;
      chk("rst_mid/release_ready_low", 32'(req_ready), 32'd0);
      step();
      chk("rst_mid/release_ready_high", 32'(req_ready), 32'd1);
      chk("rst_mid/release_no_rsp", 32'(rsp_valid), 32'd0);
      run_txn("rst_mid/fresh_read", 1'b0, 32'h0000_4000, 4'b1111, 32'h0, 32'h0BAD_F00D, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1);
   end

endmodule
